// File: rtl/fft_input_loader.sv
// Loads one N-point complex frame into the FFT sample RAM two samples per beat,
// scattering writes to bit-reversed addresses so the butterflies can run in place.
module fft_input_loader #(
    parameter  int word_size     = 16,
    parameter  int N             = 32,
    localparam int address_width = $clog2(N)
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic                     abort,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [2*word_size-1:0]   sample1,
    input  logic [2*word_size-1:0]   sample2,
    output logic [2*word_size-1:0]   comp1,
    output logic [2*word_size-1:0]   comp2,
    output logic [address_width-1:0] addr1,
    output logic [address_width-1:0] addr2,
    output logic                     wr_en,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun
);

    localparam int                 k_width = address_width - 1;
    localparam logic [k_width-1:0] k_last  = k_width'(N / 2 - 1);

    typedef enum logic [1:0] {
        IDLE,
        LOAD,
        DONE
    } state_t;

    state_t             state;
    state_t             state_next;
    logic [k_width-1:0] k;
    logic               accept;
    logic               frame_start;
    logic               overrun_set;

    function automatic logic [address_width-1:0] bitrev(input logic [address_width-1:0] v);
        logic [address_width-1:0] r;
        r = '0;
        for (int i = 0; i < address_width; i++) begin
            r[i] = v[address_width-1-i];
        end
        return r;
    endfunction

    always_comb begin
        // NOTE: every output of this block gets a default first, so no path can infer a latch.
        state_next  = state;
        in_ready    = 1'b0;
        busy        = 1'b0;
        done        = 1'b0;
        accept      = 1'b0;
        frame_start = 1'b0;
        overrun_set = 1'b0;

        unique case (state)
            IDLE: begin
                // abort outranks a simultaneous start
                if (start && !abort) begin
                    state_next  = LOAD;
                    frame_start = 1'b1;
                end
            end
            LOAD: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                accept   = in_valid;
                if (abort) begin
                    state_next = IDLE;
                end else if (accept && k == k_last) begin
                    state_next = DONE;
                end
            end
            DONE: begin
                busy        = 1'b1;
                done        = 1'b1;
                overrun_set = in_valid;
                state_next  = IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            k <= '0;
        end else if (frame_start || (state == LOAD && abort)) begin
            k <= '0;
        end else if (accept) begin
            k <= k + 1'b1;
        end
    end

    // NOTE: the write-port registers are reset because their values are visible on the RAM port.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_en <= 1'b0;
            addr1 <= '0;
            addr2 <= '0;
            comp1 <= '0;
            comp2 <= '0;
        end else begin
            wr_en <= accept;
            if (accept) begin
                addr1 <= bitrev({k, 1'b0});
                addr2 <= bitrev({k, 1'b1});
                comp1 <= sample1;
                comp2 <= sample2;
            end
        end
    end

    // set and clear live in different states, so they never collide
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            overrun <= 1'b0;
        end else if (frame_start) begin
            overrun <= 1'b0;
        end else if (overrun_set) begin
            overrun <= 1'b1;
        end
    end

endmodule

// File: tb/tb_fft_input_loader.sv
// Directed bench for fft_input_loader at N=32: full, gapped, aborted, reset-interrupted
// and back-to-back frames, checked against a hand-written bit-reversal table.
module tb_fft_input_loader;

    localparam int W  = 16;
    localparam int NN = 32;
    localparam int AW = 5;

    logic            clk = 1'b0;
    logic            reset = 1'b1;
    logic            start = 1'b0;
    logic            abort = 1'b0;
    logic            in_valid = 1'b0;
    logic            in_ready;
    logic [2*W-1:0]  sample1 = '0;
    logic [2*W-1:0]  sample2 = '0;
    logic [2*W-1:0]  comp1;
    logic [2*W-1:0]  comp2;
    logic [AW-1:0]   addr1;
    logic [AW-1:0]   addr2;
    logic            wr_en;
    logic            busy;
    logic            done;
    logic            overrun;

    // bit-reverse of k over 4 bits; addr1 = {0,br4[k]}, addr2 = {1,br4[k]}
    localparam logic [3:0] br4 [16] = '{4'd0, 4'd8, 4'd4, 4'd12, 4'd2, 4'd10, 4'd6, 4'd14,
                                        4'd1, 4'd9, 4'd5, 4'd13, 4'd3, 4'd11, 4'd7, 4'd15};

    int n_checks = 0;
    int n_pass   = 0;

    logic [AW-1:0]  log_a1   [256];
    logic [AW-1:0]  log_a2   [256];
    logic [2*W-1:0] log_c1   [256];
    logic [2*W-1:0] log_c2   [256];
    logic           log_done [256];
    int             wr_count   = 0;
    int             done_count = 0;

    fft_input_loader #(.word_size(W), .N(NN)) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .abort    (abort),
        .in_valid (in_valid),
        .in_ready (in_ready),
        .sample1  (sample1),
        .sample2  (sample2),
        .comp1    (comp1),
        .comp2    (comp2),
        .addr1    (addr1),
        .addr2    (addr2),
        .wr_en    (wr_en),
        .busy     (busy),
        .done     (done),
        .overrun  (overrun)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (wr_en) begin
            log_a1[wr_count]   <= addr1;
            log_a2[wr_count]   <= addr2;
            log_c1[wr_count]   <= comp1;
            log_c2[wr_count]   <= comp2;
            log_done[wr_count] <= done;
            wr_count           <= wr_count + 1;
        end
        if (done) done_count <= done_count + 1;
    end

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [2*W-1:0] x_of(input int n);
        return {16'(n), 16'(16'h100 + n)};
    endfunction

    task automatic drive_beat(input int b);
        sample1  = x_of(2 * b);
        sample2  = x_of(2 * b + 1);
        in_valid = 1'b1;
    endtask

    task automatic check_writes(input int base, input int count);
        for (int b = 0; b < count; b++) begin
            check("addr1", log_a1[base+b], {1'b0, br4[b]});
            check("addr2", log_a2[base+b], {1'b1, br4[b]});
            check("comp1", log_c1[base+b], x_of(2 * b));
            check("comp2", log_c2[base+b], x_of(2 * b + 1));
        end
    endtask

    // full frame: start, 16 beats (optionally gapped), in_valid held 'hold' cycles past the last beat
    task automatic run_frame(input int hold, input bit gapped, input int start_at);
        int base;
        int dbase;
        base  = wr_count;
        dbase = done_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        check("ld_ready", in_ready, 1'b1);
        check("ovr_clr", overrun, 1'b0);
        for (int b = 0; b < 16; b++) begin
            drive_beat(b);
            start = (b == start_at);
            tick();
            start = 1'b0;
            if (gapped && b != 15) begin
                in_valid = 1'b0;
                tick();
                check("wr_gap", wr_en, 1'b0);
                check("hold_a1", addr1, {1'b0, br4[b]});
            end
        end
        check("done_hi", done, 1'b1);
        check("last_wr", wr_en, 1'b1);
        check("rdy_lo", in_ready, 1'b0);
        in_valid = (hold > 0);
        tick();
        check("idle_gap", busy, 1'b0);
        check("done_lo", done, 1'b0);
        for (int h = 1; h < hold; h++) tick();
        in_valid = 1'b0;
        check_writes(base, 16);
        check("n_writes", wr_count - base, 16);
        check("n_done", done_count - dbase, 1);
        check("done_w16", log_done[base+15], 1'b1);
    endtask

    initial begin
        int base;
        int dbase;

        // asynchronous reset state
        #1 reset = 1'b0;
        #1;
        check("rst_state", {in_ready, wr_en, done, busy, overrun}, 5'b0);
        check("rst_addr", {addr1, addr2}, '0);
        check("rst_comp", {comp1, comp2}, '0);
        #10 reset = 1'b1;

        // in_valid while idle: no writes, no overrun, stays idle
        base     = wr_count;
        in_valid = 1'b1;
        repeat (3) tick();
        in_valid = 1'b0;
        check("idle_busy", busy, 1'b0);
        check("idle_ovr", overrun, 1'b0);
        check("idle_nwr", wr_count - base, 0);

        // continuous frame
        run_frame(0, 1'b0, -1);
        // gapped frame, back-to-back with the previous one
        run_frame(0, 1'b1, -1);
        check("gap_ovr", overrun, 1'b0);

        // in_valid held past DONE sets sticky overrun
        run_frame(3, 1'b0, -1);
        check("ovr_set", overrun, 1'b1);
        repeat (2) tick();
        check("ovr_hold", overrun, 1'b1);
        // start clears it (checked inside) ; start during LOAD at beat 7 is ignored
        run_frame(0, 1'b0, 7);

        // abort together with beat 5
        base  = wr_count;
        dbase = done_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < 6; b++) begin
            drive_beat(b);
            abort = (b == 5);
            tick();
        end
        abort    = 1'b0;
        in_valid = 1'b0;
        check("abt_busy", busy, 1'b0);
        check("abt_wr", wr_en, 1'b1);
        repeat (2) tick();
        check("abt_nwr", wr_count - base, 6);
        check("abt_ndone", done_count - dbase, 0);
        check_writes(base, 6);
        run_frame(0, 1'b0, -1);

        // start with abort in IDLE: abort wins
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        check("sa_busy", busy, 1'b0);
        check("sa_ready", in_ready, 1'b0);

        // reset at beat 9
        base  = wr_count;
        dbase = done_count;
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int b = 0; b < 9; b++) begin
            drive_beat(b);
            tick();
        end
        check("pre_rst_a1", addr1, {1'b0, br4[8]});
        #5;
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check("mid_rst_st", {in_ready, wr_en, done, busy, overrun}, 5'b0);
        check("mid_rst_ad", {addr1, addr2}, '0);
        check("mid_rst_cp", {comp1, comp2}, '0);
        #1 reset = 1'b1;
        repeat (3) tick();
        check("rst_nwr", wr_count - base, 9);
        check("rst_ndone", done_count - dbase, 0);
        check("rst_busy", busy, 1'b0);
        run_frame(0, 1'b0, -1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
